// File: rtl/vm_pkg.sv
// Shared vending-machine constants: coin denominations, hopper bit order,
// refund FSM encoding and the money register width.
package vm_pkg;
    localparam int MONEY_W   = 16;
    localparam int NUM_DENOM = 4;

    localparam int EJ_50   = 0;
    localparam int EJ_100  = 1;
    localparam int EJ_500  = 2;
    localparam int EJ_1000 = 3;

    // Indexed by EJ_* so a one-hot choice lines up with EJECT directly
    localparam logic [NUM_DENOM-1:0][MONEY_W-1:0] DENOM =
        {16'd1000, 16'd500, 16'd100, 16'd50};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;
endpackage

// File: rtl/change_dispenser_if.sv
// Bundle between the change dispenser, the money register, the coin
// acceptor and the hopper.
interface change_dispenser_if #(parameter int STOCK_W = 8);
    logic                       RETURN_REQ;
    logic [vm_pkg::MONEY_W-1:0] BALANCE;
    logic                       REFILL;
    logic                       COIN_IN_1000, COIN_IN_500, COIN_IN_100, COIN_IN_50;
    logic                       MINUS_1000, MINUS_500, MINUS_100, MINUS_50;
    logic [3:0]                 EJECT;
    logic                       BUSY, DONE, FAIL;
    logic [STOCK_W-1:0]         STOCK_1000, STOCK_500, STOCK_100, STOCK_50;

    modport master (
        output RETURN_REQ, BALANCE, REFILL,
               COIN_IN_1000, COIN_IN_500, COIN_IN_100, COIN_IN_50,
        input  MINUS_1000, MINUS_500, MINUS_100, MINUS_50,
               EJECT, BUSY, DONE, FAIL,
               STOCK_1000, STOCK_500, STOCK_100, STOCK_50
    );

    modport slave (
        input  RETURN_REQ, BALANCE, REFILL,
               COIN_IN_1000, COIN_IN_500, COIN_IN_100, COIN_IN_50,
        output MINUS_1000, MINUS_500, MINUS_100, MINUS_50,
               EJECT, BUSY, DONE, FAIL,
               STOCK_1000, STOCK_500, STOCK_100, STOCK_50
    );
endinterface

// File: rtl/change_dispenser_coin_stock.sv
// Per-denomination coin counter: load to INIT_STOCK, saturating increment,
// non-wrapping decrement.
module coin_stock #(
    parameter int STOCK_W    = 8,
    parameter int INIT_STOCK = 10
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               load,
    input  logic               inc,
    input  logic               dec,
    output logic [STOCK_W-1:0] count
);
    localparam logic [STOCK_W-1:0] INIT = STOCK_W'(INIT_STOCK);
    localparam logic [STOCK_W-1:0] ONE  = STOCK_W'(1);

    always_ff @(posedge CLK) begin
        if (RST || load)
            count <= INIT;
        else if (inc) begin
            if (count != '1) count <= count + ONE;
        end else if (dec) begin
            if (count != '0) count <= count - ONE;
        end
    end
endmodule

// File: rtl/change_dispenser.sv
// Refund engine: greedy largest-coin-first selection, one coin per three
// cycles, with MINUS/EJECT strobes and per-denomination stock tracking.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int STOCK_W    = 8,
    parameter int INIT_STOCK = 10
) (
    input  logic              CLK,
    input  logic              RST,
    change_dispenser_if.slave bus
);
    logic [2:0]                            state;
    logic [NUM_DENOM-1:0]                  sel_q, pick, coin_in, inc, dec, eject;
    logic [NUM_DENOM-1:0][STOCK_W-1:0]     stock;
    logic                                  fail_q, idle, load;

    assign idle = (state == S_IDLE);
    assign load = idle && bus.REFILL && !bus.RETURN_REQ;

    assign coin_in[EJ_1000] = bus.COIN_IN_1000;
    assign coin_in[EJ_500]  = bus.COIN_IN_500;
    assign coin_in[EJ_100]  = bus.COIN_IN_100;
    assign coin_in[EJ_50]   = bus.COIN_IN_50;

    // Coins are only counted while the acceptor is allowed to take them
    assign inc = idle ? coin_in : '0;
    assign dec = (state == S_ISSUE) ? sel_q : '0;

    // Ascending scan so the largest fitting, in-stock coin wins
    always_comb begin
        pick = '0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            if (bus.BALANCE >= DENOM[i] && stock[i] != '0) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_DENOM; g++) begin : g_stock
        coin_stock #(.STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK)) u_stock (
            .CLK   (CLK),
            .RST   (RST),
            .load  (load),
            .inc   (inc[g]),
            .dec   (dec[g]),
            .count (stock[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            sel_q  <= '0;
            fail_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.RETURN_REQ) begin
                    state  <= S_SELECT;
                    fail_q <= 1'b0;
                end
                S_SELECT: begin
                    if (bus.BALANCE == '0) begin
                        state  <= S_FINISH;
                        fail_q <= 1'b0;
                    end else if (pick != '0) begin
                        sel_q <= pick;
                        state <= S_ISSUE;
                    end else begin
                        state  <= S_FINISH;
                        fail_q <= 1'b1;
                    end
                end
                S_ISSUE:  state <= S_SETTLE;
                // Gives the money register a cycle to present the new balance
                S_SETTLE: state <= S_SELECT;
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign eject          = (state == S_ISSUE) ? sel_q : '0;
    assign bus.EJECT      = eject;
    assign bus.MINUS_1000 = eject[EJ_1000];
    assign bus.MINUS_500  = eject[EJ_500];
    assign bus.MINUS_100  = eject[EJ_100];
    assign bus.MINUS_50   = eject[EJ_50];
    assign bus.BUSY       = !idle;
    assign bus.DONE       = (state == S_FINISH);
    assign bus.FAIL       = (state == S_FINISH) && fail_q;
    assign bus.STOCK_1000 = stock[EJ_1000];
    assign bus.STOCK_500  = stock[EJ_500];
    assign bus.STOCK_100  = stock[EJ_100];
    assign bus.STOCK_50   = stock[EJ_50];
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: models the money register and predicts each
// refund (coin list, pulse cycles, DONE/FAIL, stocks) with a greedy model.
module tb_change_dispenser;
    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] bal, ld_val;
    logic        ld;
    logic [3:0]  coin;

    int n_chk  = 0;
    int n_pass = 0;
    int mst[4];
    int DEN[4] = '{50, 100, 500, 1000};

    always #5 CLK = ~CLK;

    change_dispenser_if #(.STOCK_W(8)) bus();

    change_dispenser #(.STOCK_W(8), .INIT_STOCK(10)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Money register: loadable, decremented by the MINUS pulses
    always @(posedge CLK) begin
        if (ld)                  bal <= ld_val;
        else if (bus.MINUS_1000) bal <= bal - 16'd1000;
        else if (bus.MINUS_500)  bal <= bal - 16'd500;
        else if (bus.MINUS_100)  bal <= bal - 16'd100;
        else if (bus.MINUS_50)   bal <= bal - 16'd50;
    end

    assign bus.BALANCE      = bal;
    assign bus.COIN_IN_1000 = coin[3];
    assign bus.COIN_IN_500  = coin[2];
    assign bus.COIN_IN_100  = coin[1];
    assign bus.COIN_IN_50   = coin[0];

    function automatic logic [10:0] outv();
        return {bus.EJECT, bus.MINUS_1000, bus.MINUS_500, bus.MINUS_100, bus.MINUS_50,
                bus.BUSY, bus.DONE, bus.FAIL};
    endfunction

    function automatic int stock_obs(int i);
        case (i)
            0:       return int'(bus.STOCK_50);
            1:       return int'(bus.STOCK_100);
            2:       return int'(bus.STOCK_500);
            default: return int'(bus.STOCK_1000);
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
        n_chk++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    task automatic chk_stocks(string tag);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s stock%0d", tag, DEN[i]), 32'(stock_obs(i)), 32'(mst[i]));
    endtask

    // Full refund: request at edge 0, check every cycle through BUSY falling.
    task automatic refund(string tag, int b, bit noisy, bit refill_too);
        int         coins[$];
        int         st[4];
        int         rem;
        int         k;
        int         p;
        logic [3:0] ej;
        logic [10:0] want;
        st  = mst;
        rem = b;
        while (rem > 0) begin
            p = -1;
            for (int i = 3; i >= 0; i--)
                if (p < 0 && rem >= DEN[i] && st[i] > 0) p = i;
            if (p < 0) break;
            coins.push_back(p);
            st[p]--;
            rem -= DEN[p];
        end
        k = coins.size();
        @(negedge CLK) ld_val = 16'(b); ld = 1'b1;
        @(negedge CLK) ld = 1'b0; bus.RETURN_REQ = 1'b1; bus.REFILL = refill_too;
        @(negedge CLK) bus.RETURN_REQ = 1'b0; bus.REFILL = 1'b0;
        for (int c = 1; c <= 3*k + 3; c++) begin
            ej = 4'b0;
            if (c >= 2 && (c - 2) % 3 == 0 && (c - 2) / 3 < k) ej = 4'b1 << coins[(c - 2) / 3];
            want = {ej, ej, c <= 3*k + 2, c == 3*k + 2, (c == 3*k + 2) && (rem != 0)};
            chk($sformatf("%s cyc%0d", tag, c), 32'(outv()), 32'(want));
            if (noisy) begin
                coin           = (c <= 3*k + 2) ? 4'b1111 : 4'b0000;
                bus.RETURN_REQ = (c <= 3*k + 2);
            end
            @(negedge CLK);
        end
        coin = 4'b0;
        bus.RETURN_REQ = 1'b0;
        mst = st;
        chk({tag, " balance"}, 32'(bal), 32'(rem));
        chk_stocks(tag);
    endtask

    task automatic coin_burst(int i, int n);
        for (int j = 0; j < n; j++) begin
            @(negedge CLK) coin = 4'b0;
            coin[i] = 1'b1;
        end
        @(negedge CLK) coin = 4'b0;
        mst[i] = (mst[i] + n > 255) ? 255 : mst[i] + n;
    endtask

    task automatic do_refill();
        @(negedge CLK) bus.REFILL = 1'b1;
        @(negedge CLK) bus.REFILL = 1'b0;
        for (int i = 0; i < 4; i++) mst[i] = 10;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; ld = 1'b0; ld_val = '0; coin = '0;
        bus.RETURN_REQ = 1'b0; bus.REFILL = 1'b0;
        for (int i = 0; i < 4; i++) mst[i] = 10;
        repeat (2) @(negedge CLK);
        chk("reset outputs", 32'(outv()), 32'(0));
        chk_stocks("reset");
        RST = 1'b0;

        refund("r1650", 1650, 1'b0, 1'b0);
        repeat (9) refund("drain500", 500, 1'b0, 1'b0);
        refund("r1500_no500", 1500, 1'b0, 1'b0);
        refund("r30", 30, 1'b0, 1'b0);
        refund("r120", 120, 1'b0, 1'b0);
        // REFILL together with RETURN_REQ must be dropped (500 stock stays 0)
        refund("req_and_refill", 1000, 1'b0, 1'b1);
        do_refill();
        chk_stocks("refill");

        coin_burst(1, 300);
        chk_stocks("coin100 sat");
        refund("busy_noise", 1000, 1'b1, 1'b0);

        // Reset during the second ISSUE of a 1650 refund
        do_refill();
        @(negedge CLK) ld_val = 16'd1650; ld = 1'b1;
        @(negedge CLK) ld = 1'b0; bus.RETURN_REQ = 1'b1;
        @(negedge CLK) bus.RETURN_REQ = 1'b0;
        repeat (4) @(negedge CLK);
        chk("mid issue500", 32'(outv()), 32'(11'b0100_0100_100));
        RST = 1'b1;
        @(negedge CLK);
        chk("mid reset outputs", 32'(outv()), 32'(0));
        for (int i = 0; i < 4; i++) mst[i] = 10;
        chk_stocks("mid reset");
        RST = 1'b0;

        for (int n = 0; n < 14; n++) begin
            case ($urandom_range(0, 5))
                0:       coin_burst($urandom_range(0, 3), $urandom_range(1, 20));
                1:       do_refill();
                default: refund($sformatf("rnd%0d", n), 10 * $urandom_range(0, 300), 1'($urandom_range(0, 1)), 1'b0);
            endcase
        end
        chk_stocks("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Refund/change engine downstream of the money register. On a return request it reads the 16-bit balance and, one coin at a time, picks the largest coin denomination that fits and is in stock. For each coin it issues the matching single-cycle MINUS pulse to the money register and an eject strobe to the coin hopper. It keeps a per-denomination coin stock, refilled by accepted coins and by a service refill.

## Interface
- STOCK_W, 8, width of each coin stock counter
- INIT_STOCK, 10, stock value loaded on reset and on REFILL
- CLK  in  1  system clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- RETURN_REQ  in  1  refund request; sampled only in IDLE
- BALANCE  in  16  unsigned current credit, from money register OUT
- REFILL  in  1  load all four stocks with INIT_STOCK; honoured only in IDLE
- COIN_IN_1000 / COIN_IN_500 / COIN_IN_100 / COIN_IN_50  in  1 each  accepted-coin pulses; increment the matching stock
- MINUS_1000 / MINUS_500 / MINUS_100 / MINUS_50  out  1 each  one-cycle decrement pulses to the money register
- EJECT  out  4  one-hot hopper strobe; bit3=1000, bit2=500, bit1=100, bit0=50
- BUSY  out  1  high in every state except IDLE; the coin acceptor gates on it
- DONE  out  1  one-cycle pulse when a refund sequence ends
- FAIL  out  1  one-cycle pulse with DONE when the remaining balance is nonzero
- STOCK_1000 / STOCK_500 / STOCK_100 / STOCK_50  out  STOCK_W each  current coin counts

## Operation
- States: IDLE, SELECT, ISSUE, SETTLE, FINISH.
- IDLE, RETURN_REQ=1: go to SELECT.
- IDLE, REFILL=1 and RETURN_REQ=0: load stocks. If both are high, RETURN_REQ wins and REFILL is dropped.
- SELECT, BALANCE==0: go to FINISH with FAIL=0.
- SELECT, otherwise: pick the first of 1000, 500, 100, 50 with BALANCE>=d and STOCK_d>0.
  - Match found: latch it and go to ISSUE.
  - No match: go to FINISH with FAIL=1. This covers balance<50, a balance that is not a multiple of 50, and depleted stock.
- ISSUE:
  - Assert MINUS_d and EJECT[d] for exactly this cycle.
  - STOCK_d decrements at the closing edge.
  - Then go to SETTLE.
- SETTLE: one idle cycle so the registered BALANCE reflects the decrement. Then go to SELECT.
- FINISH: DONE=1, and FAIL as latched. Then go to IDLE.
- COIN_IN_x:
  - In IDLE: stock +1, saturating at 2^STOCK_W-1.
  - While BUSY: ignored; no stock change.
- At most one MINUS line is high in any cycle. MINUS and EJECT are always identical and one-hot or zero.
- RETURN_REQ while BUSY is ignored. It is not queued.

## Timing
- Reset, effective at the next edge: state=IDLE, all stocks=INIT_STOCK, MINUS_*=0, EJECT=0, BUSY=0, DONE=0, FAIL=0.
- RST mid-sequence aborts the sequence. Coins already ejected are not restored to stock.
- RETURN_REQ sampled at edge N gives BUSY=1 from cycle N+1 (SELECT). The first ISSUE is in cycle N+2.
- Each coin costs 3 cycles (SELECT, ISSUE, SETTLE). Consecutive ISSUE cycles are 3 apart.
- Refund of k coins: DONE in cycle N+3k+2. BUSY falls in cycle N+3k+3.
- Zero balance: DONE in cycle N+2 and no pulses.
- All outputs are registered. MINUS/EJECT are decoded from registered state plus the latched choice, with no combinational path from BALANCE.
- BALANCE is assumed stable apart from this block's own decrements, because upstream coin acceptance is blocked by BUSY.

## Structure
- Shared package/header vm_pkg:
  - denomination constants 1000/500/100/50
  - EJECT bit indices
  - state encoding
  - 16-bit money width
- One sub-module, coin_stock: a saturating STOCK_W up/down counter with load, instantiated four times.
- The FSM and greedy selector live in change_dispenser.

## Test plan
- Stocks 10 each, BALANCE=1650 (bench models the money register), request at edge 0 -> EJECT 1000, 500, 100, 50 in cycles 2, 5, 8, 11; DONE in cycle 14, FAIL=0; final balance 0; stocks 9/9/9/9.
- STOCK_500=0, BALANCE=1500 -> one 1000 then five 100; balance 0; DONE after 6 coins, at cycle 20.
- BALANCE=30 -> no pulses; DONE+FAIL in cycle 2.
- BALANCE=120, stocks 10 -> one 100 pulse; then DONE+FAIL with balance 20.
- RST asserted in the second ISSUE of a 1650 refund -> next cycle all outputs 0, state IDLE, stocks 10.
- COIN_IN_100 pulsed 300 times in IDLE with STOCK_W=8 -> STOCK_100 saturates at 255. COIN_IN_100 while BUSY -> no change.
